// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32 load/store initiator converting byte requests into aligned word accesses
//
// Purpose:
//   Sits between the multicycle core's MEM stage and a byte-addressable,
//   word-organised memory. Each request becomes at most one word read and
//   at most one word write. Sub-word stores are done as read-modify-write.
//   Loads are lane-extracted and sign- or zero-extended.
//
// Ports:
//   clk, resetn         clock, synchronous active-low reset
//   req_valid/ready     core request handshake (ready only in IDLE)
//   req_we              1 = store, 0 = load
//   req_funct3          RV32 funct3 (size in [1:0], unsigned-load flag in [2])
//   req_addr            byte address
//   req_wdata           store data (low bytes used for SB/SH)
//   resp_valid          one-cycle completion pulse
//   resp_rdata          extended load data (0 for stores and faults)
//   resp_fault          misaligned, out of range or illegal funct3
//   memRead/memWrite    state-decoded memory strobes, never both high
//   address             word-aligned address {addr[31:2],2'b00}
//   writeData           store word, little-endian
//   memData             read word, valid the cycle after memRead

module load_store_unit #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        memRead,
  output logic        memWrite,
  output logic [31:0] address,
  output logic [31:0] writeData,
  input  logic [31:0] memData
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD      = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR      = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t state, state_nx;

  // Request fields latched at acceptance
  logic        l_we;
  logic [2:0]  l_f3;
  logic [1:0]  l_lane;
  logic [31:0] l_wdata;

  // ---------------------------------------------------------------------
  // Request decode (only meaningful in IDLE with req_valid)
  // ---------------------------------------------------------------------
  logic [31:0] req_base;
  logic [32:0] req_top;
  logic        req_illegal;
  logic        req_misaligned;
  logic        req_out_of_range;
  logic        req_fault;
  logic        req_is_sw;

  assign req_base = {req_addr[31:2], 2'b00};
  // 33-bit sum so a base near 2^32 cannot wrap back into range
  assign req_top  = {1'b0, req_base} + 33'd3;

  always_comb begin
    req_illegal = 1'b0;
    if (req_we) begin
      req_illegal = (req_funct3 != 3'b000) && (req_funct3 != 3'b001) &&
                    (req_funct3 != 3'b010);
    end else begin
      req_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                    (req_funct3 == 3'b111);
    end
  end

  assign req_misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                            ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign req_out_of_range = (req_top >= 33'(MEM_BYTES));
  assign req_fault        = req_illegal || req_misaligned || req_out_of_range;
  assign req_is_sw        = req_we && (req_funct3 == 3'b010);

  // ---------------------------------------------------------------------
  // Load lane extraction and store merge, both on the captured memData
  // ---------------------------------------------------------------------
  logic [31:0] byte_shifted;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic [31:0] lane_mask;
  logic [31:0] lane_data;
  logic [31:0] merged;

  assign byte_shifted = memData >> {l_lane, 3'b000};
  assign half_sel     = l_lane[1] ? memData[31:16] : memData[15:0];

  always_comb begin
    load_ext = memData;
    case (l_f3)
      3'b000:  load_ext = {{24{byte_shifted[7]}}, byte_shifted[7:0]};
      3'b100:  load_ext = {24'h000000, byte_shifted[7:0]};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_ext = {16'h0000, half_sel};
      default: load_ext = memData;
    endcase
  end

  // SB replaces one byte, SH one half (half lane picked by addr[1]; the
  // alignment check already guarantees l_lane[0]=0 for SH).
  always_comb begin
    lane_mask = 32'h0000_0000;
    lane_data = 32'h0000_0000;
    if (l_f3[1:0] == 2'b00) begin
      lane_mask = 32'h0000_00FF << {l_lane, 3'b000};
      lane_data = {24'h000000, l_wdata[7:0]} << {l_lane, 3'b000};
    end else begin
      lane_mask = l_lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      lane_data = l_lane[1] ? {l_wdata[15:0], 16'h0000} : {16'h0000, l_wdata[15:0]};
    end
  end

  assign merged = (memData & ~lane_mask) | (lane_data & lane_mask);

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (req_fault) begin
            state_nx = S_RESP;
          end else if (req_is_sw) begin
            state_nx = S_WR;
          end else begin
            state_nx = S_RD;
          end
        end
      end
      S_RD:      state_nx = S_RD_WAIT;
      S_RD_WAIT: state_nx = l_we ? S_WR : S_RESP;
      S_WR:      state_nx = S_RESP;
      S_RESP:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      l_we       <= 1'b0;
      l_f3       <= 3'b000;
      l_lane     <= 2'b00;
      l_wdata    <= 32'h0;
      address    <= 32'h0;
      writeData  <= 32'h0;
      resp_rdata <= 32'h0;
      resp_fault <= 1'b0;
    end else begin
      if (state == S_IDLE && req_valid) begin
        l_we       <= req_we;
        l_f3       <= req_funct3;
        l_lane     <= req_addr[1:0];
        l_wdata    <= req_wdata;
        address    <= req_base;
        // SW goes straight to WR; sub-word stores get the merged word later
        writeData  <= (req_is_sw && !req_fault) ? req_wdata : 32'h0;
        resp_rdata <= 32'h0;
        resp_fault <= req_fault;
      end else if (state == S_RD_WAIT) begin
        if (l_we) begin
          writeData <= merged;
        end else begin
          resp_rdata <= load_ext;
        end
      end
    end
  end

  // Strobes are qualified with resetn so an asserted reset never lets a
  // half-finished read-modify-write reach memory.
  assign req_ready  = (state == S_IDLE);
  assign memRead    = (state == S_RD)   && resetn;
  assign memWrite   = (state == S_WR)   && resetn;
  assign resp_valid = (state == S_RESP) && resetn;

endmodule
